// File: rtl/keypad_pkg.sv
// keypad_pkg: shared widths, scan-result and FSM encodings for the
// 4x4 keypad scanner.
package keypad_pkg;

   localparam int KP_ROWS   = 4;
   localparam int KP_COLS   = 4;
   localparam int KP_CODE_W = 4;

   typedef enum logic [1:0] {
      RES_NONE   = 2'd0,
      RES_SINGLE = 2'd1,
      RES_MULTI  = 2'd2
   } res_kind_e;

   typedef struct packed {
      res_kind_e              kind;
      logic [KP_CODE_W-1:0]   code;
   } scan_res_t;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESSED = 1'b1
   } kp_state_e;

   localparam scan_res_t NO_RES = '{kind: RES_NONE, code: '0};

   // Code is kept zero unless SINGLE so whole-struct compares are exact.
   function automatic scan_res_t merge_row(
      input scan_res_t          acc,
      input logic [1:0]         ridx,
      input logic [KP_COLS-1:0] hit
   );
      scan_res_t  r;
      logic [2:0] n;
      logic [1:0] c;
      r = acc;
      n = '0;
      c = '0;
      for (int i = 0; i < KP_COLS; i++) begin
         if (hit[i]) begin
            n = n + 3'd1;
            c = 2'(i);
         end
      end
      if (n == 3'd1 && acc.kind == RES_NONE) begin
         r.kind = RES_SINGLE;
         r.code = {ridx, c};
      end else if (n != 3'd0) begin
         r.kind = RES_MULTI;
         r.code = '0;
      end
      return r;
   endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// keypad_scan_if: keypad pins plus the debounced key-event outputs.
interface keypad_scan_if;
   import keypad_pkg::*;

   logic [KP_ROWS-1:0]   row;
   logic [KP_COLS-1:0]   col;
   logic [KP_CODE_W-1:0] key_code;
   logic                 key_valid;
   logic                 key_down;

   modport master (
      output row,
      input  col,
      output key_code,
      output key_valid,
      output key_down
   );

   modport slave (
      input  row,
      output col,
      input  key_code,
      input  key_valid,
      input  key_down
   );

endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: stability counter over whole-scan results and the
// press/release FSM that turns stable results into key events.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  scan_res_t            res_i,
   input  logic                 res_stb_i,
   output logic [KP_CODE_W-1:0] key_code_o,
   output logic                 key_valid_o,
   output logic                 key_down_o
);

   localparam int            CW   = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE);

   kp_state_e            state_q, state_d;
   scan_res_t            prev_q, prev_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [KP_CODE_W-1:0] code_q, code_d;
   logic                 valid_q, valid_d;
   logic                 down_q, down_d;
   logic                 settled;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         prev_q  <= NO_RES;
         cnt_q   <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         down_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         down_q  <= down_d;
      end
   end

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      valid_d = 1'b0;
      down_d  = down_q;
      if (res_stb_i) begin
         prev_d = res_i;
         if (res_i == prev_q)
            cnt_d = (cnt_q == CMAX) ? cnt_q : cnt_q + CW'(1);
         else
            cnt_d = CW'(1);
      end
      // Only the step into saturation counts; a held result stays quiet.
      settled = res_stb_i && cnt_d == CMAX && cnt_q != CMAX;
      unique case (state_q)
         ST_IDLE: begin
            if (settled && res_i.kind == RES_SINGLE) begin
               code_d  = res_i.code;
               valid_d = 1'b1;
               down_d  = 1'b1;
               state_d = ST_PRESSED;
            end
         end
         ST_PRESSED: begin
            if (settled && res_i.kind == RES_NONE) begin
               down_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   assign key_code_o  = code_q;
   assign key_valid_o = valid_q;
   assign key_down_o  = down_q;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: row driver, column synchronizer and per-scan accumulator
// for a 4x4 matrix keypad, feeding the debouncer once per full scan.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter int DEBOUNCE = 4
) (
   input  logic          clk,
   input  logic          rst,
   keypad_scan_if.master kp
);

   localparam int DW = $clog2(SCAN_DIV);

   logic [KP_COLS-1:0] col_m_q, col_s_q;
   logic [DW-1:0]      div_q, div_d;
   logic [1:0]         row_idx_q, row_idx_d;
   scan_res_t          acc_q, acc_d, row_res;
   logic               tick, res_stb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_m_q   <= '1;
         col_s_q   <= '1;
         div_q     <= '0;
         row_idx_q <= '0;
         acc_q     <= NO_RES;
      end else begin
         col_m_q   <= kp.col;
         col_s_q   <= col_m_q;
         div_q     <= div_d;
         row_idx_q <= row_idx_d;
         acc_q     <= acc_d;
      end
   end

   assign tick = (div_q == DW'(SCAN_DIV - 1));

   always_comb begin
      div_d     = tick ? '0 : div_q + DW'(1);
      row_idx_d = row_idx_q;
      acc_d     = acc_q;
      res_stb   = 1'b0;
      row_res   = merge_row(acc_q, row_idx_q, ~col_s_q);
      if (tick) begin
         row_idx_d = row_idx_q + 2'd1;
         if (row_idx_q == 2'd3) begin
            res_stb = 1'b1;
            acc_d   = NO_RES;
         end else begin
            acc_d = row_res;
         end
      end
   end

   assign kp.row = ~(KP_ROWS'(1) << row_idx_q);

   keypad_debounce #(
      .DEBOUNCE (DEBOUNCE)
   ) u_deb (
      .clk         (clk),
      .rst         (rst),
      .res_i       (row_res),
      .res_stb_i   (res_stb),
      .key_code_o  (kp.key_code),
      .key_valid_o (kp.key_valid),
      .key_down_o  (kp.key_down)
   );

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: keypad matrix model plus scan-level reference model
// of debounced press/release events.
module tb_keypad_scan;

   localparam int SD = 4;
   localparam int DB = 3;

   logic        clk;
   logic        rst;
   logic [15:0] keys;

   keypad_scan_if kp();

   keypad_scan #(
      .SCAN_DIV (SD),
      .DEBOUNCE (DB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .kp  (kp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Passive matrix: a pressed key shorts its column to its driven-low row.
   always_comb begin
      kp.col = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!kp.row[r] && keys[r*4+c]) kp.col[c] = 1'b0;
   end

   int          vec;
   int          errs;
   int          phase;
   int          obs_ev;
   int          hist[$];
   logic [15:0] snap;
   logic        m_down;
   logic [3:0]  m_code;

   // -1 = no key, 16 = several keys, else the key code
   function automatic int classify(input logic [15:0] k);
      int n;
      n = $countones(k);
      if (n == 0) return -1;
      if (n > 1) return 16;
      for (int i = 0; i < 16; i++) if (k[i]) return i;
      return -1;
   endfunction

   task automatic model_scan(input logic [15:0] k, output logic ev);
      int r;
      int run;
      r = classify(k);
      hist.push_back(r);
      run = 0;
      for (int i = hist.size() - 1; i >= 0 && hist[i] == r; i--) run++;
      ev = 1'b0;
      if (run == DB) begin
         if (!m_down && r >= 0 && r < 16) begin
            m_down = 1'b1;
            m_code = r[3:0];
            ev     = 1'b1;
         end else if (m_down && r < 0) begin
            m_down = 1'b0;
         end
      end
   endtask

   task automatic step();
      logic [3:0] er;
      logic       ev;
      @(posedge clk);
      #1;
      phase++;
      er = ~(4'b0001 << ((phase / 4) % 4));
      vec++;
      if (kp.row !== er) begin
         errs++;
         $display("FAIL row @%0d got %b want %b", phase, kp.row, er);
      end
      if (phase % 16 == 2) snap = keys;
      ev = 1'b0;
      if (phase % 16 == 0) model_scan(snap, ev);
      vec++;
      if (kp.key_valid !== ev) begin
         errs++;
         $display("FAIL key_valid @%0d got %b want %b", phase, kp.key_valid, ev);
      end
      vec++;
      if (kp.key_down !== m_down) begin
         errs++;
         $display("FAIL key_down @%0d got %b want %b", phase, kp.key_down, m_down);
      end
      vec++;
      if (kp.key_code !== m_code) begin
         errs++;
         $display("FAIL key_code @%0d got %0d want %0d", phase, kp.key_code, m_code);
      end
      if (kp.key_valid === 1'b1) obs_ev++;
   endtask

   task automatic scans(input logic [15:0] k, input int n);
      keys = k;
      repeat (n * 16) step();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      vec++;
      if (kp.row !== 4'b1110) begin
         errs++;
         $display("FAIL rst_row got %b want 1110", kp.row);
      end
      vec++;
      if (kp.key_code !== 4'd0 || kp.key_valid !== 1'b0 || kp.key_down !== 1'b0) begin
         errs++;
         $display("FAIL rst_out got %0d/%b/%b want 0/0/0",
                  kp.key_code, kp.key_valid, kp.key_down);
      end
      @(negedge clk);
      rst    = 1'b0;
      phase  = 0;
      m_down = 1'b0;
      m_code = '0;
      hist.delete();
   endtask

   task automatic expect_events(input string nm, input int e0, input int n,
                                input logic [3:0] code, input logic down);
      vec++;
      if (obs_ev - e0 !== n) begin
         errs++;
         $display("FAIL %s events got %0d want %0d", nm, obs_ev - e0, n);
      end
      vec++;
      if (kp.key_code !== code || kp.key_down !== down) begin
         errs++;
         $display("FAIL %s code/down got %0d/%b want %0d/%b",
                  nm, kp.key_code, kp.key_down, code, down);
      end
   endtask

   task automatic test_reset();
      do_reset();
      scans(16'h0000, 2);
      repeat (7) step();
      do_reset();
      scans(16'h0000, 2);
   endtask

   task automatic test_single_press();
      int e0;
      e0 = obs_ev;
      scans(16'h0200, 3);
      expect_events("press9", e0, 1, 4'd9, 1'b1);
      scans(16'h0200, 10);
      expect_events("hold9", e0, 1, 4'd9, 1'b1);
   endtask

   task automatic test_release();
      int e0;
      scans(16'h0000, 3);
      expect_events("rel9", obs_ev, 0, 4'd9, 1'b0);
      e0 = obs_ev;
      scans(16'h0001, 3);
      expect_events("press0", e0, 1, 4'd0, 1'b1);
      scans(16'h0000, 3);
   endtask

   task automatic test_bounce();
      int e0;
      e0   = obs_ev;
      keys = 16'h0008;
      for (int i = 1; i <= 60; i++) begin
         step();
         if (i % 5 == 0) keys = keys ^ 16'h0008;
      end
      keys = 16'h0008;
      repeat (4) step();
      expect_events("bounce", e0, 0, 4'd0, 1'b0);
      scans(16'h0008, 3);
      expect_events("settle3", e0, 1, 4'd3, 1'b1);
      scans(16'h0000, 3);
   endtask

   task automatic test_multi();
      int e0;
      e0 = obs_ev;
      scans(16'h0060, 4);
      expect_events("multi", e0, 0, 4'd3, 1'b0);
      scans(16'h0020, 3);
      expect_events("multi_to5", e0, 1, 4'd5, 1'b1);
      scans(16'h0000, 3);
   endtask

   task automatic test_reset_pressed();
      int e0;
      scans(16'h8000, 3);
      do_reset();
      e0 = obs_ev;
      scans(16'h8000, 3);
      expect_events("rst_press15", e0, 1, 4'd15, 1'b1);
      scans(16'h0000, 3);
   endtask

   task automatic test_back_to_back();
      logic [15:0] k;
      for (int s = 0; s < 30; s++) begin
         case ($urandom_range(0, 3))
            0: k = 16'h0000;
            1, 2: k = 16'h0001 << $urandom_range(0, 15);
            default: begin
               k = 16'(1 << $urandom_range(0, 15));
               while ($countones(k) < 2) k = k | 16'(1 << $urandom_range(0, 15));
            end
         endcase
         scans(k, int'($urandom_range(1, 5)));
      end
      scans(16'h0000, 3);
   endtask

   initial begin
      vec    = 0;
      errs   = 0;
      phase  = 0;
      obs_ev = 0;
      snap   = '0;
      keys   = '0;
      m_down = 1'b0;
      m_code = '0;
      rst    = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      test_reset();
      test_single_press();
      test_release();
      test_bounce();
      test_multi();
      test_reset_pressed();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
